// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle between the control unit and the
// iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, abort, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, abort, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply (radix-2 Booth) and divide (restoring) unit with
// start/busy/done handshake, abort and divide-by-zero flag.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic             a_neg_reg, a_neg_next;
    logic             q_neg_reg, q_neg_next;
    logic             dz_reg, dz_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [AW-1:0]    acc_reg, acc_next;
    logic [WIDTH:0]   m_reg, m_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             div_zero_reg, div_zero_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;

    // Operand preparation at the start edge
    logic             op_signed;
    logic [WIDTH:0]   a_ext, b_ext;
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_signed = ~bus.op[0];
    assign a_ext     = op_signed ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
    assign b_ext     = op_signed ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
    assign a_neg_in  = op_signed & bus.a[WIDTH-1];
    assign b_neg_in  = op_signed & bus.b[WIDTH-1];
    assign a_mag     = a_neg_in ? -bus.a : bus.a;
    assign b_mag     = b_neg_in ? -bus.b : bus.b;

    // Booth step: the add is done one bit wider so the shifted-in sign is
    // always the true sign of A +/- M.
    logic [WIDTH:0]   booth_a;
    logic [WIDTH:0]   booth_q;
    logic [WIDTH+1:0] booth_sum;
    logic [AW-1:0]    booth_shift;

    assign booth_a = acc_reg[AW-1:WIDTH+2];
    assign booth_q = acc_reg[WIDTH+1:1];

    always_comb begin
        booth_sum = {booth_a[WIDTH], booth_a};
        case (acc_reg[1:0])
            2'b01:   booth_sum = {booth_a[WIDTH], booth_a} + {m_reg[WIDTH], m_reg};
            2'b10:   booth_sum = {booth_a[WIDTH], booth_a} - {m_reg[WIDTH], m_reg};
            default: booth_sum = {booth_a[WIDTH], booth_a};
        endcase
    end

    assign booth_shift = {booth_sum, booth_q};

    // Restoring divide step on magnitudes; the partial remainder is always
    // below the divisor so the difference fits in WIDTH bits.
    logic [WIDTH:0]   rem_shift;
    logic             rem_fits;
    logic [WIDTH-1:0] rem_sub;

    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign rem_fits  = (rem_shift >= m_reg);
    assign rem_sub   = rem_shift[WIDTH-1:0] - m_reg[WIDTH-1:0];

    // Sign fix-up for truncating signed division
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign quo_fix = q_neg_reg ? -quo_reg : quo_reg;
    assign rem_fix = a_neg_reg ? -rem_reg : rem_reg;

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        a_neg_next    = a_neg_reg;
        q_neg_next    = q_neg_reg;
        dz_next       = dz_reg;
        count_next    = count_reg;
        acc_next      = acc_reg;
        m_next        = m_reg;
        rem_next      = rem_reg;
        quo_next      = quo_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        div_zero_next = div_zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    op_next       = bus.op;
                    busy_next     = 1'b1;
                    div_zero_next = 1'b0;
                    a_neg_next    = a_neg_in;
                    q_neg_next    = a_neg_in ^ b_neg_in;
                    dz_next       = 1'b0;
                    if (!bus.op[1]) begin
                        m_next     = a_ext;
                        acc_next   = {{(WIDTH + 1){1'b0}}, b_ext, 1'b0};
                        count_next = CW'(WIDTH);
                        state_next = MUL;
                    end else begin
                        m_next     = {1'b0, b_mag};
                        rem_next   = '0;
                        quo_next   = a_mag;
                        count_next = CW'(WIDTH - 1);
                        if (bus.b == '0) begin
                            dz_next    = 1'b1;
                            state_next = FINISH;
                        end else begin
                            state_next = DIV;
                        end
                    end
                end
            end

            MUL: begin
                if (bus.abort) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    acc_next   = booth_shift;
                    count_next = count_reg - CW'(1);
                    if (count_reg == '0) begin
                        state_next = FINISH;
                    end
                end
            end

            DIV: begin
                if (bus.abort) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    rem_next   = rem_fits ? rem_sub : rem_shift[WIDTH-1:0];
                    quo_next   = {quo_reg[WIDTH-2:0], rem_fits};
                    count_next = count_reg - CW'(1);
                    if (count_reg == '0) begin
                        state_next = FINISH;
                    end
                end
            end

            FINISH: begin
                // abort is deliberately ignored here: completion wins
                if (!op_reg[1]) begin
                    hi_next = acc_reg[2*WIDTH:WIDTH+1];
                    lo_next = acc_reg[WIDTH:1];
                end else if (dz_reg) begin
                    div_zero_next = 1'b1;
                end else begin
                    hi_next = rem_fix;
                    lo_next = quo_fix;
                end
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            a_neg_reg    <= 1'b0;
            q_neg_reg    <= 1'b0;
            dz_reg       <= 1'b0;
            count_reg    <= '0;
            acc_reg      <= '0;
            m_reg        <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            a_neg_reg    <= a_neg_next;
            q_neg_reg    <= q_neg_next;
            dz_reg       <= dz_next;
            count_reg    <= count_next;
            acc_reg      <= acc_next;
            m_reg        <= m_next;
            rem_reg      <= rem_next;
            quo_reg      <= quo_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            div_zero_reg <= div_zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit against an arithmetic
// reference model of the HI/LO results, latency and handshake.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic and SV truncating division
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          p;
        longint unsigned up;
        logic [W-1:0]    q;
        logic [W-1:0]    r;
        m_dz = 1'b0;
        case (op)
            2'd0: begin
                p    = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'd1: begin
                up   = {32'h0, a} * {32'h0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            2'd2: begin
                if (b == '0) begin
                    m_dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = '0;
                end else begin
                    q    = $signed(a) / $signed(b);
                    r    = $signed(a) % $signed(b);
                    m_lo = q;
                    m_hi = r;
                end
            end
            default: begin
                if (b == '0) begin
                    m_dz = 1'b1;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
        endcase
    endtask

    function automatic int latency(input logic [1:0] op, input logic [W-1:0] b);
        if (!op[1]) return W + 2;
        if (b == '0) return 1;
        return W + 1;
    endfunction

    // Called at a negedge. abort_k/inj_k: drive abort/start during the cycle
    // after the k-th edge following the start edge (-1 = never).
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int abort_k, input int inj_k,
                          input bit abort_with_start);
        int L;
        int k;
        bit busy_drop;
        bit done_seen;
        bit aborting;
        L = latency(op, b);
        aborting = (abort_k >= 0) && (abort_k + 1 < L);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        bus.abort = abort_with_start;
        @(negedge clk);
        k = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check({tag, " busy_at_start"}, 64'(bus.busy), 64'd1);
        busy_drop = 1'b0;
        while (!bus.done && k < L + 4) begin
            bus.abort = (k == abort_k);
            bus.start = (k == inj_k);
            if (k == inj_k) begin
                bus.op = 2'($urandom_range(0, 3));
                bus.a  = $urandom;
                bus.b  = $urandom;
            end
            @(negedge clk);
            k++;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (aborting && k == abort_k + 1) break;
            if (!bus.busy && !bus.done) busy_drop = 1'b1;
        end
        if (aborting) begin
            m_dz = 1'b0;
            check({tag, " busy_after_abort"}, 64'(bus.busy), 64'd0);
            check({tag, " done_after_abort"}, 64'(bus.done), 64'd0);
            done_seen = 1'b0;
            repeat (L + 2) begin
                @(negedge clk);
                if (bus.done) done_seen = 1'b1;
            end
            check({tag, " no_done_after_abort"}, 64'(done_seen), 64'd0);
            check({tag, " hi_kept"}, 64'(bus.hi), 64'(m_hi));
            check({tag, " lo_kept"}, 64'(bus.lo), 64'(m_lo));
            check({tag, " div_zero"}, 64'(bus.div_zero), 64'(m_dz));
        end else begin
            model(op, a, b);
            check({tag, " latency"}, 64'(k), 64'(L));
            check({tag, " busy_held"}, 64'(busy_drop), 64'd0);
            check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
            check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
            check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
            check({tag, " div_zero"}, 64'(bus.div_zero), 64'(m_dz));
            @(negedge clk);
            check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        end
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d cycles=%0d (%s)",
                 op, a, b, bus.hi, bus.lo, bus.div_zero, k, tag);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            4:       v = W'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        int           r_abort;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.abort = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset div_zero", 64'(bus.div_zero), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, -1, -1, 1'b0);
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
        run_op("mult_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
        run_op("mult_minmin", 2'd0, 32'h8000_0000, 32'h8000_0000, -1, -1, 1'b0);
        run_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
        run_op("divu_7_2", 2'd3, 32'd7, 32'd2, -1, -1, 1'b0);
        run_op("div_by_zero", 2'd2, 32'd5, 32'd0, -1, -1, 1'b0);
        run_op("divu_after_dz", 2'd3, 32'd100, 32'd7, -1, -1, 1'b0);
        run_op("mult_ignored_start", 2'd0, 32'd12345, 32'hFFFF_FD5A, -1, 5, 1'b0);
        run_op("mult_abort", 2'd0, 32'd999, 32'd777, 9, -1, 1'b0);
        run_op("divu_abort_on_finish", 2'd3, 32'hDEAD_BEEF, 32'd13, W, -1, 1'b0);
        run_op("multu_abort_on_finish", 2'd1, 32'hCAFE_F00D, 32'd3, W + 1, -1, 1'b0);
        run_op("start_with_abort_idle", 2'd1, 32'd11, 32'd13, -1, -1, 1'b1);

        // Asynchronous reset in the middle of a divide
        bus.op    = 2'd2;
        bus.a     = 32'hFFFF_0000;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst hi", 64'(bus.hi), 64'd0);
        check("midrst lo", 64'(bus.lo), 64'd0);
        check("midrst div_zero", 64'(bus.div_zero), 64'd0);
        $display("async reset mid-DIV: busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("multu_6x7", 2'd1, 32'd6, 32'd7, -1, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = pick();
            r_b  = pick();
            if (r_op[1] && $urandom_range(0, 7) == 0) r_b = '0;
            r_abort = -1;
            if (latency(r_op, r_b) > 1 && $urandom_range(0, 7) == 0)
                r_abort = $urandom_range(0, latency(r_op, r_b) - 2);
            run_op("random", r_op, r_a, r_b, r_abort, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the CPU datapath, writing the HI/LO pair. It performs signed/unsigned multiply (radix-2 Booth) and signed/unsigned divide (restoring) with a start/busy/done handshake, abort, and divide-by-zero flagging. The control unit stalls on busy and commits hi/lo after done.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH bits each; product is 2*WIDTH bits.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset (asynchronous, active-high)
start  input  1  request; sampled only when busy=0
op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start
abort  input  1  synchronous cancel of the operation in flight
a  input  WIDTH  multiplicand / dividend; sampled with start
b  input  WIDTH  multiplier / divisor; sampled with start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when hi/lo (or div_zero) updated
div_zero  output  1  high with done when divisor was zero; held until next accepted start
hi  output  WIDTH  product high half / remainder
lo  output  WIDTH  product low half / quotient

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, div_zero, hi, lo, counter, internal registers = 0.
- States: IDLE, MUL, DIV, FINISH.
- IDLE: start=1 at edge E0 -> latch a, b, op; busy=1; div_zero=0; counter loaded. MULT/MULTU -> MUL; DIV/DIVU with b!=0 -> DIV; DIV/DIVU with b=0 -> FINISH.
- start while busy=1: ignored, no queueing.
- MUL: operands extended to WIDTH+1 bits (sign-extend for MULT, zero-extend for MULTU); Booth on 2*WIDTH+3-bit accumulator {A, Q, q-1}; per cycle add +M/-M per {Q0,q-1} (01:+M, 10:-M, 00/11:none), then arithmetic shift right 1. WIDTH+1 iterations (edges E1..E(WIDTH+1)), then FINISH.
- DIV: operate on magnitudes (abs for DIV, raw for DIVU); restoring, one quotient bit per cycle, WIDTH iterations (edges E1..E(WIDTH)), then FINISH.
- FINISH (one edge): write hi/lo, done=1 for exactly this cycle, busy=0, state=IDLE.
  - MUL: {hi,lo} = low 2*WIDTH bits of product.
  - DIV: lo=quotient, hi=remainder; signed: quotient negated if signs of a,b differ, remainder takes sign of a (truncating division).
  - DIV overflow (signed, a=most-negative, b=-1): lo=a (wraps), hi=0, div_zero=0.
  - Divide by zero: hi/lo unchanged, div_zero=1.
- Latency (start edge to done-high edge): MUL WIDTH+2 cycles; DIV WIDTH+1; divide-by-zero 1.
- hi/lo hold their value between completions; never partially updated.
- abort=1 while busy: at next edge state=IDLE, busy=0, no done, hi/lo/div_zero unchanged. abort in IDLE: no effect. abort and start same edge in IDLE: start wins. Abort on the FINISH edge: completion wins (results written, done=1).
- A new start may be sampled on the edge after done (back-to-back, one idle cycle minimum not required: start is accepted on the edge where busy is already 0).
- rst mid-operation: immediate clear to reset values; no done.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 34 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> done after 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 with prior hi=1, lo=3 -> done 1 cycle after start, div_zero=1, hi=1, lo=3; next accepted start clears div_zero.
- MULT in flight: pulse start with new operands at cycle 5 -> ignored, original result delivered; abort at cycle 10 -> busy=0 next cycle, no done, hi/lo keep previous values.
- Assert rst at cycle 12 of a DIV -> busy, done, hi, lo = 0 immediately; new MULTU 6*7 after release -> lo=42, hi=0.
